multicycle_control_fsm: RTL and testbench

MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

---
 rtl/multicycle_control_fsm.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS-style control unit: per-state datapath strobes, memory-wait
// timeout into a sticky FAULT state, and an illegal-opcode pulse in DECODE.
module multicycle_control_fsm #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] aluop,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       mem_fault
);

    localparam int unsigned CW = $clog2(WAIT_LIMIT + 2);
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  RWB   = 4'd7,
        BRANCH = 4'd8,  IEXEC  = 4'd9,  IWB    = 4'd10, JUMP  = 4'd11,
        FAULT  = 4'd12
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          waiting, at_limit, legal_op;

    logic       pc_write_q, pc_write_cond_q, iord_q, mem_read_q, mem_write_q;
    logic       mem_to_reg_q, reg_dst_q, reg_write_q, alu_src_a_q, mem_fault_q;
    logic       fetch_q;
    logic [1:0] alu_src_b_q, pc_source_q;
    logic [2:0] aluop_q;
    logic       pc_write_d, pc_write_cond_d, iord_d, mem_read_d, mem_write_d;
    logic       mem_to_reg_d, reg_dst_d, reg_write_d, alu_src_a_d, mem_fault_d;
    logic       fetch_d;
    logic [1:0] alu_src_b_d, pc_source_d;
    logic [2:0] aluop_d;

    assign legal_op = opcode inside {OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_SLTI, OP_LW, OP_SW};
    assign waiting  = (state_q == FETCH || state_q == MEMRD || state_q == MEMWR) && !mem_ready;
    assign at_limit = (wait_q == LIMIT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (mem_ready) state_d = DECODE; else if (at_limit) state_d = FAULT;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:     state_d = MEMADR;
                    OP_RTYPE:         state_d = EXEC;
                    OP_BEQ:           state_d = BRANCH;
                    OP_ADDI, OP_SLTI: state_d = IEXEC;
                    OP_J:             state_d = JUMP;
                    default:          state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   if (mem_ready) state_d = MEMWB; else if (at_limit) state_d = FAULT;
            MEMWB:   state_d = FETCH;
            MEMWR:   if (mem_ready) state_d = FETCH; else if (at_limit) state_d = FAULT;
            EXEC:    state_d = RWB;
            RWB:     state_d = FETCH;
            BRANCH:  state_d = FETCH;
            IEXEC:   state_d = IWB;
            IWB:     state_d = FETCH;
            JUMP:    state_d = FETCH;
            FAULT:   state_d = FAULT;
            default: state_d = FETCH;
        endcase

        if (state_d != state_q) wait_d = '0;
        else if (waiting)       wait_d = wait_q + 1'b1;
        else                    wait_d = wait_q;
    end

    // Outputs are registered from the next state, so each flop already holds
    // the strobe pattern of the state being entered.
    always_comb begin
        pc_write_d      = 1'b0;
        pc_write_cond_d = 1'b0;
        iord_d          = 1'b0;
        mem_read_d      = 1'b0;
        mem_write_d     = 1'b0;
        mem_to_reg_d    = 1'b0;
        reg_dst_d       = 1'b0;
        reg_write_d     = 1'b0;
        alu_src_a_d     = 1'b0;
        alu_src_b_d     = 2'b00;
        pc_source_d     = 2'b00;
        aluop_d         = 3'b000;
        mem_fault_d     = 1'b0;
        fetch_d         = 1'b0;
        case (state_d)
            FETCH:  begin mem_read_d = 1'b1; alu_src_b_d = 2'b01; aluop_d = 3'b011; fetch_d = 1'b1; end
            DECODE: begin alu_src_b_d = 2'b11; aluop_d = 3'b011; end
            MEMADR: begin alu_src_a_d = 1'b1; alu_src_b_d = 2'b10; aluop_d = 3'b011; end
            MEMRD:  begin mem_read_d = 1'b1; iord_d = 1'b1; end
            MEMWB:  begin reg_write_d = 1'b1; mem_to_reg_d = 1'b1; end
            MEMWR:  begin mem_write_d = 1'b1; iord_d = 1'b1; end
            EXEC:   begin alu_src_a_d = 1'b1; end
            RWB:    begin reg_write_d = 1'b1; reg_dst_d = 1'b1; end
            BRANCH: begin
                alu_src_a_d = 1'b1; aluop_d = 3'b001; pc_write_cond_d = 1'b1; pc_source_d = 2'b01;
            end
            IEXEC:  begin
                alu_src_a_d = 1'b1; alu_src_b_d = 2'b10;
                aluop_d = (opcode == OP_ADDI) ? 3'b011 : 3'b010;
            end
            IWB:    begin reg_write_d = 1'b1; end
            JUMP:   begin pc_write_d = 1'b1; pc_source_d = 2'b10; end
            FAULT:  begin mem_fault_d = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= FETCH;
            wait_q          <= '0;
            pc_write_q      <= 1'b0;
            pc_write_cond_q <= 1'b0;
            iord_q          <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            reg_dst_q       <= 1'b0;
            reg_write_q     <= 1'b0;
            alu_src_a_q     <= 1'b0;
            alu_src_b_q     <= 2'b00;
            pc_source_q     <= 2'b00;
            aluop_q         <= 3'b000;
            mem_fault_q     <= 1'b0;
            fetch_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            wait_q          <= wait_d;
            pc_write_q      <= pc_write_d;
            pc_write_cond_q <= pc_write_cond_d;
            iord_q          <= iord_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_to_reg_q    <= mem_to_reg_d;
            reg_dst_q       <= reg_dst_d;
            reg_write_q     <= reg_write_d;
            alu_src_a_q     <= alu_src_a_d;
            alu_src_b_q     <= alu_src_b_d;
            pc_source_q     <= pc_source_d;
            aluop_q         <= aluop_d;
            mem_fault_q     <= mem_fault_d;
            fetch_q         <= fetch_d;
        end
    end

    // IR load and PC increment follow mem_ready within the fetch cycle itself.
    assign ir_write      = fetch_q & mem_ready;
    assign pc_write      = pc_write_q | (fetch_q & mem_ready);
    assign illegal_op    = (state_q == DECODE) && !legal_op;
    assign pc_write_cond = pc_write_cond_q;
    assign iord          = iord_q;
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_to_reg    = mem_to_reg_q;
    assign reg_dst       = reg_dst_q;
    assign reg_write     = reg_write_q;
    assign alu_src_a     = alu_src_a_q;
    assign alu_src_b     = alu_src_b_q;
    assign pc_source     = pc_source_q;
    assign aluop         = aluop_q;
    assign state         = state_q;
    assign mem_fault     = mem_fault_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: stimulus queues the expected
// state/strobe pattern per cycle, a monitor pops and compares on each falling edge.
module tb_multicycle_control_fsm;

    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] SLTI = 6'b001010;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BAD  = 6'b111111;

    logic       clk, rst, mem_ready;
    logic [5:0] opcode;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, mem_fault;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] aluop;
    logic [3:0] state;

    multicycle_control_fsm #(.WAIT_LIMIT(15)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .aluop(aluop), .state(state), .illegal_op(illegal_op), .mem_fault(mem_fault)
    );

    logic [22:0] dut_v;
    assign dut_v = {state, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
                    aluop, illegal_op, mem_fault};

    typedef struct {
        string       name;
        logic [22:0] v;
    } exp_t;

    exp_t sb[$];
    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written per-state strobe table, with ir_write/pc_write following
    // mem_ready in FETCH and illegal_op decoded in DECODE.
    function automatic logic [18:0] exp_o(input logic [3:0] st, input logic mr, input logic [5:0] op);
        logic pw, pwc, io, mrd, mw, irw, m2r, rd, rw, asa, ill, mf;
        logic [1:0] asb, ps;
        logic [2:0] alu;
        {pw, pwc, io, mrd, mw, irw, m2r, rd, rw, asa, ill, mf} = '0;
        asb = 2'b00; ps = 2'b00; alu = 3'b000;
        case (st)
            4'd0:  begin mrd = 1'b1; asb = 2'b01; alu = 3'b011; irw = mr; pw = mr; end
            4'd1:  begin
                asb = 2'b11; alu = 3'b011;
                ill = !(op inside {RT, JMP, BEQ, ADDI, SLTI, LW, SW});
            end
            4'd2:  begin asa = 1'b1; asb = 2'b10; alu = 3'b011; end
            4'd3:  begin mrd = 1'b1; io = 1'b1; end
            4'd4:  begin rw = 1'b1; m2r = 1'b1; end
            4'd5:  begin mw = 1'b1; io = 1'b1; end
            4'd6:  begin asa = 1'b1; alu = 3'b000; end
            4'd7:  begin rw = 1'b1; rd = 1'b1; end
            4'd8:  begin asa = 1'b1; alu = 3'b001; pwc = 1'b1; ps = 2'b01; end
            4'd9:  begin asa = 1'b1; asb = 2'b10; alu = (op == ADDI) ? 3'b011 : 3'b010; end
            4'd10: begin rw = 1'b1; end
            4'd11: begin pw = 1'b1; ps = 2'b10; end
            4'd12: begin mf = 1'b1; end
            default: ;
        endcase
        return {pw, pwc, io, mrd, mw, irw, m2r, rd, rw, asa, asb, ps, alu, ill, mf};
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endfunction

    task automatic cyc(input logic mr, input logic [5:0] op, input logic [3:0] st, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        mem_ready = mr;
        opcode    = op;
        e.name = nm;
        e.v    = {st, exp_o(st, mr, op)};
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.name, {9'd0, dut_v}, {9'd0, e.v});
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        rst = 1'b1; mem_ready = 1'b1; opcode = BAD;
        #3;
        chk("reset_outputs", {9'd0, dut_v}, 32'd0);
        mem_ready = 1'b0;
        #9 rst = 1'b0;

        // lw, zero wait
        cyc(1'b0, LW, 4'd0, "post_reset_fetch_idle");
        cyc(1'b1, LW, 4'd0, "lw_fetch");
        cyc(1'b1, LW, 4'd1, "lw_decode");
        cyc(1'b1, LW, 4'd2, "lw_memadr");
        cyc(1'b1, LW, 4'd3, "lw_memrd");
        cyc(1'b1, LW, 4'd4, "lw_memwb");
        // R-type
        cyc(1'b1, RT, 4'd0, "rt_fetch");
        cyc(1'b1, RT, 4'd1, "rt_decode");
        cyc(1'b1, RT, 4'd6, "rt_exec");
        cyc(1'b1, RT, 4'd7, "rt_rwb");
        // sw with three wait cycles
        cyc(1'b1, SW, 4'd0, "sw_fetch");
        cyc(1'b1, SW, 4'd1, "sw_decode");
        cyc(1'b1, SW, 4'd2, "sw_memadr");
        for (int unsigned i = 0; i < 3; i++) cyc(1'b0, SW, 4'd5, "sw_memwr_wait");
        cyc(1'b1, SW, 4'd5, "sw_memwr_done");
        // beq, j, addi, slti
        cyc(1'b1, BEQ, 4'd0, "beq_fetch");
        cyc(1'b1, BEQ, 4'd1, "beq_decode");
        cyc(1'b1, BEQ, 4'd8, "beq_branch");
        cyc(1'b1, JMP, 4'd0, "j_fetch");
        cyc(1'b1, JMP, 4'd1, "j_decode");
        cyc(1'b1, JMP, 4'd11, "j_jump");
        cyc(1'b1, ADDI, 4'd0, "addi_fetch");
        cyc(1'b1, ADDI, 4'd1, "addi_decode");
        cyc(1'b1, ADDI, 4'd9, "addi_iexec");
        cyc(1'b1, ADDI, 4'd10, "addi_iwb");
        cyc(1'b1, SLTI, 4'd0, "slti_fetch");
        cyc(1'b1, SLTI, 4'd1, "slti_decode");
        cyc(1'b1, SLTI, 4'd9, "slti_iexec");
        cyc(1'b1, SLTI, 4'd10, "slti_iwb");
        // illegal opcode
        cyc(1'b1, BAD, 4'd0, "ill_fetch");
        cyc(1'b1, BAD, 4'd1, "ill_decode_pulse");
        cyc(1'b0, BAD, 4'd0, "ill_back_to_fetch");
        // ready arriving exactly at the wait limit still completes
        cyc(1'b1, LW, 4'd0, "lim_fetch");
        cyc(1'b1, LW, 4'd1, "lim_decode");
        cyc(1'b1, LW, 4'd2, "lim_memadr");
        for (int unsigned i = 0; i < 15; i++) cyc(1'b0, LW, 4'd3, "lim_memrd_wait");
        cyc(1'b1, LW, 4'd3, "lim_memrd_ready_at_limit");
        cyc(1'b1, LW, 4'd4, "lim_memwb_no_fault");
        // async reset in the middle of BRANCH
        cyc(1'b1, BEQ, 4'd0, "beqr_fetch");
        cyc(1'b1, BEQ, 4'd1, "beqr_decode");
        cyc(1'b1, BEQ, 4'd8, "beqr_branch");
        @(negedge clk);
        #2;
        rst = 1'b1; mem_ready = 1'b0;
        #1;
        chk("branch_async_rst_pwc", {31'd0, pc_write_cond}, 32'd0);
        chk("branch_async_rst_state", {28'd0, state}, 32'd0);
        #1 rst = 1'b0;
        cyc(1'b1, RT, 4'd0, "rt2_fetch");
        cyc(1'b1, RT, 4'd1, "rt2_decode");
        cyc(1'b1, RT, 4'd6, "rt2_exec");
        cyc(1'b1, RT, 4'd7, "rt2_rwb");
        // 16 waiting edges in FETCH reach the limit and fault
        for (int unsigned i = 0; i < 16; i++) cyc(1'b0, RT, 4'd0, "flt_fetch_wait");
        cyc(1'b0, RT, 4'd12, "flt_fault");
        cyc(1'b1, RT, 4'd12, "flt_fault_sticky");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("fault_rst_clears", {9'd0, dut_v}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
